// File: rtl/osc_pkg.sv
// Shared types and constants for the oscillating counter sequencer.
package osc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } osc_state_t;

   localparam int unsigned NBITS_COUNT_DEFAULT = 2;
   localparam int unsigned PRESCALE_W          = 8;

endpackage

// File: rtl/osc_tick_gen.sv
// Prescaler: emits a registered one-cycle tick every PRESCALE enabled cycles.
// A clear restarts the period and drops any tick that would have been emitted.
module osc_tick_gen #(
   parameter int unsigned PRESCALE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);
   import osc_pkg::*;

   localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

   logic [PRESCALE_W-1:0] cnt_d;
   logic [PRESCALE_W-1:0] cnt_q;
   logic                  tick_d;
   logic                  tick_q;

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + PRESCALE_W'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/osc_sequencer.sv
// Drives an up/down counter so it sweeps between LIMIT_LO and LIMIT_HI at a prescaled rate.
// Optional OSC_TURN_COUNT_EN adds a saturating 'turns' output counting direction reversals.
module osc_sequencer #(
   parameter int unsigned NBITS_COUNT = osc_pkg::NBITS_COUNT_DEFAULT,
   parameter int unsigned PRESCALE    = 4,
   parameter int unsigned LIMIT_LO    = 0,
   parameter int unsigned LIMIT_HI    = (2 ** NBITS_COUNT) - 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   load_req,
   input  logic [NBITS_COUNT-1:0] load_value,
   input  logic [NBITS_COUNT-1:0] count_fb,
   output logic                   load,
   output logic                   count_up,
   output logic                   counter_on,
   output logic [NBITS_COUNT-1:0] Data_in,
   output logic                   running
`ifdef OSC_TURN_COUNT_EN
   ,
   output logic [7:0]             turns
`endif
);
   import osc_pkg::*;

   localparam int                     LO_I = int'(LIMIT_LO);
   localparam int                     HI_I = int'(LIMIT_HI);
   localparam logic [NBITS_COUNT-1:0] LO_V = NBITS_COUNT'(LIMIT_LO);
   localparam logic [NBITS_COUNT-1:0] HI_V = NBITS_COUNT'(LIMIT_HI);

   function automatic logic [NBITS_COUNT-1:0] clamp(input logic [NBITS_COUNT-1:0] v);
      if (int'(v) < LO_I) begin
         return LO_V;
      end else if (int'(v) > HI_I) begin
         return HI_V;
      end else begin
         return v;
      end
   endfunction

   osc_state_t             state_d;
   osc_state_t             state_q;
   logic                   counter_on_d, counter_on_q;
   logic                   count_up_d, count_up_q;
   logic                   running_d, running_q;
   logic                   load_d, load_q;
   logic [NBITS_COUNT-1:0] data_d, data_q;
   logic                   pend_d, pend_q;
   logic [NBITS_COUNT-1:0] pend_val_d, pend_val_q;

   logic busy_s, entry_s, tick_s, at_hi_s, at_lo_s, next_up_s, blocked_s;

   assign busy_s  = load_req | pend_q;
   assign at_hi_s = int'(count_fb) >= HI_I;
   assign at_lo_s = int'(count_fb) <= LO_I;

   osc_tick_gen #(
      .PRESCALE(PRESCALE)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .clear (entry_s | pend_q),
      .enable(state_q != IDLE),
      .tick  (tick_s)
   );

   // A load in flight freezes the FSM; otherwise stop beats start, and each tick
   // decides direction and pulse together so no tick is lost at a turn.
   always_comb begin
      state_d      = state_q;
      counter_on_d = 1'b0;
      count_up_d   = count_up_q;
      entry_s      = 1'b0;
      next_up_s    = (state_q == UP);
      blocked_s    = 1'b0;
      if (busy_s) begin
         state_d = state_q;
      end else if (stop) begin
         state_d = IDLE;
      end else if (state_q == IDLE) begin
         if (start) begin
            state_d    = UP;
            count_up_d = 1'b1;
            entry_s    = 1'b1;
         end else begin
            state_d = IDLE;
         end
      end else if (tick_s) begin
         if ((state_q == UP) && at_hi_s) begin
            next_up_s = 1'b0;
         end else if ((state_q == DOWN) && at_lo_s) begin
            next_up_s = 1'b1;
         end else begin
            next_up_s = (state_q == UP);
         end
         blocked_s = next_up_s ? at_hi_s : at_lo_s;
         if (blocked_s) begin
            state_d = state_q;
         end else begin
            state_d      = next_up_s ? UP : DOWN;
            counter_on_d = 1'b1;
            count_up_d   = next_up_s;
         end
      end else begin
         state_d = state_q;
      end
   end

   always_comb begin
      pend_d    = load_req;
      load_d    = pend_q;
      running_d = (state_q != IDLE);
      if (load_req) begin
         pend_val_d = clamp(load_value);
      end else begin
         pend_val_d = pend_val_q;
      end
      if (pend_q) begin
         data_d = pend_val_q;
      end else begin
         data_d = data_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         counter_on_q <= 1'b0;
         count_up_q   <= 1'b1;
         running_q    <= 1'b0;
         load_q       <= 1'b0;
         data_q       <= '0;
         pend_q       <= 1'b0;
         pend_val_q   <= '0;
      end else begin
         state_q      <= state_d;
         counter_on_q <= counter_on_d;
         count_up_q   <= count_up_d;
         running_q    <= running_d;
         load_q       <= load_d;
         data_q       <= data_d;
         pend_q       <= pend_d;
         pend_val_q   <= pend_val_d;
      end
   end

   assign load       = load_q;
   assign count_up   = count_up_q;
   assign counter_on = counter_on_q;
   assign Data_in    = data_q;
   assign running    = running_q;

`ifdef OSC_TURN_COUNT_EN
   logic       turn_s;
   logic [7:0] turns_d, turns_q;

   assign turn_s = counter_on_d & (count_up_d != (state_q == UP));

   always_comb begin
      if (entry_s) begin
         turns_d = 8'd0;
      end else if (turn_s && (turns_q != 8'hFF)) begin
         turns_d = turns_q + 8'd1;
      end else begin
         turns_d = turns_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         turns_q <= 8'd0;
      end else begin
         turns_q <= turns_d;
      end
   end

   assign turns = turns_q;
`endif

endmodule

// File: tb/tb_osc_sequencer.sv
// Scoreboard bench: two sequencers, each with a behavioural up/down counter attached.
module tb_osc_sequencer;
   localparam int NB = 2;

   typedef struct {
      logic [NB-1:0] val;
      int            gap;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          a_start, a_stop, a_load_req, a_load, a_count_up, a_counter_on, a_running;
   logic [NB-1:0] a_load_value, a_count, a_data_in;
   logic          b_start, b_stop, b_load_req, b_load, b_count_up, b_counter_on, b_running;
   logic [NB-1:0] b_load_value, b_count, b_data_in;
`ifdef OSC_TURN_COUNT_EN
   logic [7:0]    a_turns, b_turns;
`endif

   osc_sequencer #(.NBITS_COUNT(NB), .PRESCALE(2), .LIMIT_LO(0), .LIMIT_HI(3)) dut_a (
      .clk(clk), .reset(rst_n), .start(a_start), .stop(a_stop), .load_req(a_load_req),
      .load_value(a_load_value), .count_fb(a_count), .load(a_load), .count_up(a_count_up),
      .counter_on(a_counter_on), .Data_in(a_data_in), .running(a_running)
`ifdef OSC_TURN_COUNT_EN
      , .turns(a_turns)
`endif
   );

   osc_sequencer #(.NBITS_COUNT(NB), .PRESCALE(3), .LIMIT_LO(1), .LIMIT_HI(2)) dut_b (
      .clk(clk), .reset(rst_n), .start(b_start), .stop(b_stop), .load_req(b_load_req),
      .load_value(b_load_value), .count_fb(b_count), .load(b_load), .count_up(b_count_up),
      .counter_on(b_counter_on), .Data_in(b_data_in), .running(b_running)
`ifdef OSC_TURN_COUNT_EN
      , .turns(b_turns)
`endif
   );

   // Downstream two-bit up/down counters: load wins over counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_count <= '0;
         b_count <= '0;
      end else begin
         if (a_load) a_count <= a_data_in;
         else if (a_counter_on) a_count <= a_count_up ? a_count + 2'd1 : a_count - 2'd1;
         if (b_load) b_count <= b_data_in;
         else if (b_counter_on) b_count <= b_count_up ? b_count + 2'd1 : b_count - 2'd1;
      end
   end

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t qa[$];
   exp_t qb[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic push_a(input int v, input int gap);
      exp_t e;
      e.val = NB'(v);
      e.gap = gap;
      qa.push_back(e);
   endtask

   task automatic push_b(input int v, input int gap);
      exp_t e;
      e.val = NB'(v);
      e.gap = gap;
      qb.push_back(e);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_a(input int budget);
      int n = 0;
      while (qa.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("a_queue_drained", qa.size(), 0);
   endtask

   task automatic wait_b(input int budget);
      int n = 0;
      while (qb.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("b_queue_drained", qb.size(), 0);
   endtask

   // Monitor: each change of a counter is popped against the scoreboard (value and spacing).
   int            cyc = 0;
   int            a_last = 0, b_last = 0;
   logic [NB-1:0] a_prev = '0, b_prev = '0;
   exp_t          ea, eb;
   initial forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && (a_count != a_prev)) begin
         if (qa.size() == 0) begin
            check("a_unexpected_change", int'(a_count), int'(a_prev));
         end else begin
            ea = qa.pop_front();
            check("a_count_value", int'(a_count), int'(ea.val));
            if (ea.gap != 0) check("a_count_gap", cyc - a_last, ea.gap);
         end
         a_last = cyc;
      end
      if (rst_n && (b_count != b_prev)) begin
         if (qb.size() == 0) begin
            check("b_unexpected_change", int'(b_count), int'(b_prev));
         end else begin
            eb = qb.pop_front();
            check("b_count_value", int'(b_count), int'(eb.val));
            if (eb.gap != 0) check("b_count_gap", cyc - b_last, eb.gap);
         end
         b_last = cyc;
      end
      a_prev = a_count;
      b_prev = b_count;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      a_start = 1'b0; a_stop = 1'b0; a_load_req = 1'b0; a_load_value = '0;
      b_start = 1'b0; b_stop = 1'b0; b_load_req = 1'b0; b_load_value = '0;
      cycles(2);
      check("rst_load", int'(a_load), 0);
      check("rst_counter_on", int'(a_counter_on), 0);
      check("rst_count_up", int'(a_count_up), 1);
      check("rst_data_in", int'(a_data_in), 0);
      check("rst_running", int'(a_running), 0);
      rst_n = 1'b1;
      cycles(1);

      // start and stop together while idle
      a_start = 1'b1; a_stop = 1'b1;
      cycles(4);
      check("idle_both_running", int'(a_running), 0);
      check("idle_both_counter_on", int'(a_counter_on), 0);

      // full sweep 0..3..0..2, one step every 2 cycles
      push_a(1, 0); push_a(2, 2); push_a(3, 2); push_a(2, 2);
      push_a(1, 2); push_a(0, 2); push_a(1, 2); push_a(2, 2);
      a_stop = 1'b0;
      wait_a(60);
      check("sweep_running", int'(a_running), 1);
      check("sweep_count_up", int'(a_count_up), 1);
`ifdef OSC_TURN_COUNT_EN
      check("turns_after_two_reversals", int'(a_turns), 2);
`endif

      // stop at Count=2 going up: the pending tick is suppressed
      a_stop = 1'b1; a_start = 1'b0;
      cycles(1);
      check("stop_counter_on_k1", int'(a_counter_on), 0);
      cycles(1);
      check("stop_running", int'(a_running), 0);
      check("stop_counter_on_k2", int'(a_counter_on), 0);
      a_stop = 1'b0;
      cycles(4);
      check("stop_count_holds", int'(a_count), 2);

      // resume upward from 2, then load 3 while going down at 1
      push_a(3, 0); push_a(2, 2); push_a(1, 2);
      a_start = 1'b1;
      wait_a(40);
      check("down_count_up", int'(a_count_up), 0);
      push_a(3, 3); push_a(2, 0); push_a(1, 2); push_a(0, 2); push_a(1, 2);
      a_load_req = 1'b1; a_load_value = 2'd3;
      cycles(1);
      a_load_req = 1'b0; a_load_value = 2'd0;
      check("load_not_yet", int'(a_load), 0);
      cycles(1);
      check("load_pulse", int'(a_load), 1);
      check("load_data", int'(a_data_in), 3);
      check("load_counter_on", int'(a_counter_on), 0);
      cycles(1);
      check("load_one_cycle", int'(a_load), 0);
      check("load_data_held", int'(a_data_in), 3);
      wait_a(40);
      a_stop = 1'b1; a_start = 1'b0;
      cycles(2);
      a_stop = 1'b0;

      // reset while sweeping down
      push_a(2, 0); push_a(3, 2); push_a(2, 2);
      a_start = 1'b1;
      wait_a(40);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_load", int'(a_load), 0);
      check("midrst_counter_on", int'(a_counter_on), 0);
      check("midrst_count_up", int'(a_count_up), 1);
      check("midrst_data_in", int'(a_data_in), 0);
      check("midrst_running", int'(a_running), 0);
      a_start = 1'b0;
      cycles(2);
      rst_n = 1'b1;
      cycles(1);

      // limits 1..2: clamped load from below, sweep, clamped load from above
      b_load_req = 1'b1; b_load_value = 2'd0;
      push_b(1, 0);
      cycles(1);
      b_load_req = 1'b0;
      cycles(1);
      check("b_load_pulse", int'(b_load), 1);
      check("b_clamp_lo", int'(b_data_in), 1);
      wait_b(20);
      push_b(2, 0); push_b(1, 3); push_b(2, 3); push_b(1, 3);
      b_start = 1'b1;
      wait_b(60);
      check("b_running", int'(b_running), 1);
      push_b(2, 0);
      b_load_req = 1'b1; b_load_value = 2'd3;
      cycles(1);
      b_load_req = 1'b0;
      cycles(1);
      check("b_load_pulse_hi", int'(b_load), 1);
      check("b_clamp_hi", int'(b_data_in), 2);
      check("b_load_counter_on", int'(b_counter_on), 0);
      wait_b(20);
      b_stop = 1'b1; b_start = 1'b0;
      cycles(3);
      b_stop = 1'b0;
      cycles(6);
      check("final_a_queue", qa.size(), 0);
      check("final_b_queue", qb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
